// File: rtl/priority_encoder8_stream.sv
// Sequential 8-to-3 encoder: captures a request vector, then streams the index of
// each set bit (priority order set by MSB_FIRST), clearing bits as they are accepted.
module priority_encoder8_stream #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [2:0] out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_none,
  output logic       out_last,
  output logic [3:0] out_count
);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [7:0] mask_q, mask_d;
  logic [3:0] count_q, count_d;
  logic       none_q, none_d;
  logic [2:0] idx;
  logic [3:0] pending;

  function automatic logic [3:0] popcnt(input logic [7:0] m);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, m[i]};
    return c;
  endfunction

  // Later matches overwrite earlier ones, so scan direction picks the priority end.
  function automatic logic [2:0] pick_idx(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    if (MSB_FIRST) begin
      for (int i = 0; i < 8; i++) if (m[i]) r = i[2:0];
    end else begin
      for (int i = 7; i >= 0; i--) if (m[i]) r = i[2:0];
    end
    return r;
  endfunction

  always_comb begin
    idx     = pick_idx(mask_q);
    pending = popcnt(mask_q);
    state_d = state_q;
    mask_d  = mask_q;
    count_d = count_q;
    none_d  = none_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mask_d  = in;
          count_d = popcnt(in);
          none_d  = (in == 8'd0);
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          mask_d = mask_q & ~(8'd1 << idx);
          if (pending <= 4'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= 8'd0;
      count_q <= 4'd0;
      none_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      none_q  <= none_d;
    end
  end

  // Beat outputs are forced low outside EMIT so an empty mask in IDLE shows nothing.
  assign out_valid = (state_q == EMIT);
  assign in_ready  = rst_n & (state_q == IDLE);
  assign out       = out_valid ? idx : 3'd0;
  assign out_last  = out_valid & (pending <= 4'd1);
  assign out_none  = out_valid & none_q;
  assign out_count = count_q;

endmodule

// File: tb/tb_priority_encoder8_stream.sv
// Bench for priority_encoder8_stream: runs both priority orders in lockstep against
// index lists derived directly from each captured vector.
module tb_priority_encoder8_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in;
  logic       in_valid;
  logic       out_ready;

  logic       m_in_ready, m_out_valid, m_out_none, m_out_last;
  logic [2:0] m_out;
  logic [3:0] m_out_count;
  logic       l_in_ready, l_out_valid, l_out_none, l_out_last;
  logic [2:0] l_out;
  logic [3:0] l_out_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  priority_encoder8_stream #(.MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .in(in), .in_valid(in_valid), .in_ready(m_in_ready),
    .out(m_out), .out_valid(m_out_valid), .out_ready(out_ready), .out_none(m_out_none),
    .out_last(m_out_last), .out_count(m_out_count)
  );

  priority_encoder8_stream #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .in(in), .in_valid(in_valid), .in_ready(l_in_ready),
    .out(l_out), .out_valid(l_out_valid), .out_ready(out_ready), .out_none(l_out_none),
    .out_last(l_out_last), .out_count(l_out_count)
  );

  // Drives one vector and follows its whole output stream. mode: 0 ready always,
  // 1 ready pattern 1,0,0 repeating, 2 random ready.
  task automatic send(input logic [7:0] v, input int mode, input string name);
    logic [2:0] exp_m[$];
    logic [2:0] exp_l[$];
    int n, k, cyc;
    logic [3:0] exp_cnt;
    logic exp_none;
    for (int i = 7; i >= 0; i--) if (v[i]) exp_m.push_back(3'(i));
    for (int i = 0; i < 8; i++) if (v[i]) exp_l.push_back(3'(i));
    if (v == 8'd0) begin
      exp_m.push_back(3'd0);
      exp_l.push_back(3'd0);
    end
    n = exp_m.size();
    exp_cnt = 4'($countones(v));
    exp_none = (v == 8'd0);

    @(negedge clk);
    checks++;
    if (m_in_ready !== 1'b1 || l_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready_idle: got msb=%b lsb=%b want 1", name, m_in_ready, l_in_ready);
    end
    in = v;
    in_valid = 1'b1;
    @(negedge clk);
    k = 0;
    cyc = 0;
    while (k < n && cyc < 64) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      in_valid = 1'($urandom_range(0, 1));
      in = 8'($urandom);
      checks++;
      if (m_out_valid !== 1'b1 || l_out_valid !== 1'b1 || m_in_ready !== 1'b0 || l_in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s valid_ready beat%0d: got vld=%b/%b rdy=%b/%b want vld=1 rdy=0",
                 name, k, m_out_valid, l_out_valid, m_in_ready, l_in_ready);
      end
      checks++;
      if (m_out !== exp_m[k] || l_out !== exp_l[k]) begin
        errors++;
        $display("FAIL %s index beat%0d: got msb=%0d lsb=%0d want msb=%0d lsb=%0d",
                 name, k, m_out, l_out, exp_m[k], exp_l[k]);
      end
      checks++;
      if (m_out_last !== (k == n - 1) || l_out_last !== (k == n - 1)) begin
        errors++;
        $display("FAIL %s last beat%0d: got %b/%b want %b", name, k, m_out_last, l_out_last, (k == n - 1));
      end
      checks++;
      if (m_out_none !== exp_none || l_out_none !== exp_none ||
          m_out_count !== exp_cnt || l_out_count !== exp_cnt) begin
        errors++;
        $display("FAIL %s none_count beat%0d: got none=%b/%b cnt=%0d/%0d want none=%b cnt=%0d",
                 name, k, m_out_none, l_out_none, m_out_count, l_out_count, exp_none, exp_cnt);
      end
      @(negedge clk);
      if (out_ready) k++;
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (k < n) begin
      errors++;
      $display("FAIL %s timeout: got %0d beats want %0d", name, k, n);
    end
    checks++;
    if (m_out_valid !== 1'b0 || l_out_valid !== 1'b0 || m_in_ready !== 1'b1 || l_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s back_to_idle: got vld=%b/%b rdy=%b/%b want vld=0 rdy=1",
               name, m_out_valid, l_out_valid, m_in_ready, l_in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in = 8'd0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (m_out_valid !== 1'b0 || l_out_valid !== 1'b0 || m_in_ready !== 1'b0 || l_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: got vld=%b/%b rdy=%b/%b want 0",
               m_out_valid, l_out_valid, m_in_ready, l_in_ready);
    end
    checks++;
    if (m_out !== 3'd0 || m_out_last !== 1'b0 || m_out_none !== 1'b0 || m_out_count !== 4'd0) begin
      errors++;
      $display("FAIL reset_outputs: got out=%0d last=%b none=%b cnt=%0d want 0",
               m_out, m_out_last, m_out_none, m_out_count);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_bits();
    send(8'b0000_0010, 0, "single1");
    send(8'b0000_1000, 0, "single3");
    send(8'b0010_0000, 0, "single5");
    send(8'b1000_0000, 0, "single7");
  endtask

  task automatic test_multi_bit();
    send(8'b1010_0101, 0, "multiA5");
  endtask

  task automatic test_backpressure();
    send(8'hFF, 1, "bpFF");
  endtask

  task automatic test_zero_vector();
    send(8'h00, 0, "zero");
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 20; t++) send(8'($urandom), 2, "random");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in = 8'hF0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (m_out !== 3'd7 || l_out !== 3'd4) begin
      errors++;
      $display("FAIL rstmid_beat0: got msb=%0d lsb=%0d want 7/4", m_out, l_out);
    end
    @(negedge clk);
    checks++;
    if (m_out !== 3'd6 || l_out !== 3'd5) begin
      errors++;
      $display("FAIL rstmid_beat1: got msb=%0d lsb=%0d want 6/5", m_out, l_out);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (m_out_valid !== 1'b0 || l_out_valid !== 1'b0 || m_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_abort: got vld=%b/%b rdy=%b want vld=0 rdy=0",
               m_out_valid, l_out_valid, m_in_ready);
    end
    rst_n = 1'b1;
    out_ready = 1'b0;
    send(8'h01, 0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_single_bits();
    test_multi_bit();
    test_backpressure();
    test_zero_vector();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/priority_encoder8_stream.md
Name: priority_encoder8_stream

Overview:
- Sequential 8-to-3 encoder: the companion to the team's 3-to-8 Decoder8.
- It accepts an 8-bit request vector through a valid/ready handshake and stores it.
- It then emits the 3-bit index of every set bit, one per output handshake, in priority order, clearing each bit as it is sent.
- It feeds Decoder8-based select logic and bench scoreboards that rebuild one-hot codes from a stream of indices.

Parameters:
- MSB_FIRST, 1, priority order. 1: highest set bit is emitted first (bit 7 first). 0: lowest set bit is emitted first (bit 0 first).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- in  input  8  request vector
- in_valid  input  1  request vector is present on `in`
- in_ready  output  1  block can accept a vector
- out  output  3  encoded index of the current bit
- out_valid  output  1  `out`, `out_none`, `out_last` and `out_count` are valid
- out_ready  input  1  downstream accepts the current index
- out_none  output  1  the captured vector was 8'b0
- out_last  output  1  current beat is the final beat of this vector
- out_count  output  4  number of set bits in the captured vector (0..8)

Behaviour:
- Reset (sampled at posedge while rst_n=0):
  - state=IDLE, pending mask=0, out_count=0, none flag=0.
  - out_valid=0, out=0, out_last=0, out_none=0.
  - in_ready=0 during any cycle with rst_n=0; in_ready=1 from the first cycle after release.
- States: IDLE, EMIT.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid=1 at a posedge: mask<=in, out_count<=popcount(in), none<=(in==0), state<=EMIT.
- EMIT:
  - in_ready=0; in_valid is ignored.
  - out_valid=1.
  - out = index of the priority bit of mask, combinational from registered state.
  - out_last = (popcount(mask)<=1).
  - out_none = none flag.
- Latency: input handshake at posedge N gives out_valid=1 in the cycle after N, with the first index visible. One index per cycle when out_ready is held high.
- Output handshake (out_valid & out_ready at a posedge):
  - Clear the emitted bit in mask.
  - If out_last=1: state<=IDLE, so in_ready=1 in the next cycle.
  - Back-to-back throughput: one vector per popcount+1 cycles. There is no input/output overlap.
- Backpressure: while out_valid=1 and out_ready=0, out, out_last, out_none and out_count hold stable; mask is unchanged.
- Zero vector: emits exactly one beat with out=0, out_none=1, out_last=1, out_count=0.
- Single-bit vector: one beat with out_last=1 and out_none=0. This is the inverse of Decoder8.
- out_count is constant for all beats of a vector. It is cleared only by reset; it holds its last value in IDLE but is don't-care while out_valid=0.
- Reset mid-EMIT: aborts immediately. Remaining bits are discarded and no further beats are sent.
- Glitch-free rule: all outputs are functions of registers only. No combinational path from `in` to `out`, or from in_valid to out_valid.

Test Plan:
- Single bits: apply in=8'b00000010, 8'b00001000, 8'b00100000, 8'b10000000 (the Decoder8 outputs for 1, 3, 5, 7) with out_ready=1 -> one beat each: out=1, 3, 5, 7 respectively, out_last=1, out_count=1, out_none=0.
- Multi-bit, MSB_FIRST=1: in=8'b10100101, out_ready=1 -> out=7, 5, 2, 0 on four consecutive cycles; out_last=1 only on 0; out_count=4 throughout; in_ready returns to 1 on the next cycle.
- Multi-bit, MSB_FIRST=0: in=8'b10100101 -> out=0, 2, 5, 7.
- Backpressure: in=8'hFF with out_ready toggled 1,0,0,1,... -> out=7..0 each seen exactly once, values stable while stalled; in_valid pulses during EMIT are ignored (in_ready=0).
- Zero vector: in=8'h00 -> one beat with out_none=1, out_last=1, out=0, out_count=0, then IDLE.
- Reset mid-operation: in=8'hF0, accept 2 beats (7, 6), drive rst_n=0 for one cycle -> out_valid=0 next cycle. After release, in=8'h01 -> single beat out=0; no stale 5/4 emitted.
